// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for a 256x8 synchronous-read data memory.
// CPU has default priority; DMA wins on starvation or while continuing a held burst.
module dmem_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_stall,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       dma_req,
  input  logic       dma_burst,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic [7:0] dma_rdata,
  output logic       dma_rvalid,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_TOP = 3'(STARVE_LIM);
  localparam logic [3:0] BURST_TOP  = 4'(BURST_MAX);

  state_t     state, state_nx;
  logic [2:0] starve_cnt, starve_nx;
  logic [3:0] burst_cnt, burst_nx;
  logic       starved, burst_hold, dma_pri;
  logic       cpu_win, dma_win;
  logic       cpu_rd_q, dma_rd_q;
  logic [7:0] cpu_rdata_q, dma_rdata_q;

  // Winner selection; reset low suppresses every grant.
  always_comb begin
    starved    = (starve_cnt == STARVE_TOP);
    burst_hold = (state == S_DMA) && dma_burst && (burst_cnt < BURST_TOP);
    dma_pri    = starved || burst_hold;
    dma_win    = reset && dma_req && (!cpu_req || dma_pri);
    cpu_win    = reset && cpu_req && !dma_win;
  end

  assign cpu_stall = reset && cpu_req && !cpu_win;
  assign dma_gnt   = dma_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    state_nx  = S_IDLE;
    starve_nx = 3'd0;
    burst_nx  = 4'd0;
    if (cpu_win) begin
      state_nx = S_CPU;
    end else if (dma_win) begin
      state_nx = S_DMA;
    end
    if (dma_req && !dma_win) begin
      starve_nx = starved ? starve_cnt : starve_cnt + 3'd1;
    end
    // Burst length saturates so a long uncontested DMA run cannot wrap back into priority.
    if (dma_win) begin
      if (state != S_DMA) begin
        burst_nx = 4'd1;
      end else if (burst_cnt >= BURST_TOP) begin
        burst_nx = burst_cnt;
      end else begin
        burst_nx = burst_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      starve_cnt  <= 3'd0;
      burst_cnt   <= 4'd0;
      cpu_rd_q    <= 1'b0;
      dma_rd_q    <= 1'b0;
      cpu_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      burst_cnt  <= burst_nx;
      cpu_rd_q   <= cpu_win && !cpu_we;
      dma_rd_q   <= dma_win && !dma_we;
      if (cpu_rd_q) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (dma_rd_q) begin
        dma_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory data arrives one cycle after the grant; pass it through then hold it.
  assign cpu_rvalid = cpu_rd_q;
  assign dma_rvalid = dma_rd_q;
  assign cpu_rdata  = cpu_rd_q ? mem_rdata : cpu_rdata_q;
  assign dma_rdata  = dma_rd_q ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter.
// Directed scenarios plus random traffic scored against a cycle-level arbitration model.
module tb_dmem_arbiter;
  localparam int STARVE_LIM = 4;
  localparam int BURST_MAX  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_burst, dma_we, dma_gnt, dma_rvalid;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.STARVE_LIM(STARVE_LIM), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_burst(dma_burst), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return (a == 16) ? 8'h5A : 8'((a * 7 + 3) & 255);
  endfunction

  // Synchronous-read data memory driven only by the DUT's mem_* outputs.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model state: consecutive DMA denials, consecutive DMA grants, expected returns.
  logic [7:0] ref_mem [256];
  int         wait_cnt, run_len;
  logic       exp_cv, exp_dv;
  logic [7:0] exp_cd, exp_dd;
  logic       last_cw, last_dw;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic cr, input logic cwe, input logic [7:0] ca, input logic [7:0] cwd,
                      input logic dr, input logic db, input logic dwe, input logic [7:0] da,
                      input logic [7:0] dwd);
    logic dpri, dw, cw, ncv, ndv;
    logic [7:0] ncd, ndd;
    @(negedge clk);
    reset = r;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_burst = db; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
    #2;
    if (!r) begin
      expect_eq("rst_mem_en", mem_en, 0);
      expect_eq("rst_mem_we", mem_we, 0);
      expect_eq("rst_dma_gnt", dma_gnt, 0);
      expect_eq("rst_cpu_stall", cpu_stall, 0);
      expect_eq("rst_cpu_rvalid", cpu_rvalid, 0);
      expect_eq("rst_dma_rvalid", dma_rvalid, 0);
      expect_eq("rst_cpu_rdata", cpu_rdata, 0);
      expect_eq("rst_dma_rdata", dma_rdata, 0);
      wait_cnt = 0; run_len = 0;
      exp_cv = 0; exp_dv = 0; exp_cd = 0; exp_dd = 0;
      last_cw = 0; last_dw = 0;
      return;
    end
    dpri = (wait_cnt >= STARVE_LIM) || (run_len > 0 && run_len < BURST_MAX && db);
    dw = dr && (!cr || dpri);
    cw = cr && !dw;
    expect_eq("cpu_stall", cpu_stall, cr && !cw);
    expect_eq("dma_gnt", dma_gnt, dw);
    expect_eq("mem_en", mem_en, cw || dw);
    expect_eq("mem_we", mem_we, cw ? cwe : (dw ? dwe : 1'b0));
    expect_eq("mem_addr", mem_addr, cw ? ca : (dw ? da : 8'h00));
    expect_eq("mem_wdata", mem_wdata, cw ? cwd : (dw ? dwd : 8'h00));
    expect_eq("cpu_rvalid", cpu_rvalid, exp_cv);
    expect_eq("cpu_rdata", cpu_rdata, exp_cd);
    expect_eq("dma_rvalid", dma_rvalid, exp_dv);
    expect_eq("dma_rdata", dma_rdata, exp_dd);
    ncv = cw && !cwe; ndv = dw && !dwe;
    ncd = ref_mem[ca]; ndd = ref_mem[da];
    if (cw && cwe) ref_mem[ca] = cwd;
    if (dw && dwe) ref_mem[da] = dwd;
    wait_cnt = (dr && !dw) ? ((wait_cnt + 1 > STARVE_LIM) ? STARVE_LIM : wait_cnt + 1) : 0;
    run_len  = dw ? ((run_len + 1 > BURST_MAX) ? BURST_MAX : run_len + 1) : 0;
    exp_cv = ncv; exp_dv = ndv;
    if (ncv) exp_cd = ncd;
    if (ndv) exp_dd = ndd;
    last_cw = cw; last_dw = dw;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k, cyc, run, run_at_cpu;
    logic cr, cpu_done;
    logic c_pend, c_we, d_pend, d_we, d_burst, r;
    logic [7:0] c_a, c_d, d_a, d_d;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    reset = 0;
    step(0, 1, 0, 8'h10, 0, 1, 0, 0, 8'h11, 0);
    step(0, 1, 1, 8'h12, 8'h99, 1, 1, 1, 8'h13, 8'h98);
    step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    expect_eq("first_grant_mem_en", mem_en, 1);

    // Lone CPU read of the preloaded 0x5A location.
    idle(1);
    step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    expect_eq("t029_stall", cpu_stall, 0);
    expect_eq("t029_en", mem_en, 1);
    idle(1);
    expect_eq("t029_rvalid", cpu_rvalid, 1);
    expect_eq("t029_rdata", cpu_rdata, 8'h5A);

    // Contention: CPU four times, then the starved DMA.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 8'(i), 0, 1, 0, 1, 8'h80, 8'h77);
      expect_eq("t030_gnt", dma_gnt, (i == 4));
      expect_eq("t030_stall", cpu_stall, (i == 4));
    end
    idle(2);

    // Burst of ten writes with a single CPU access raised after the first grant.
    k = 0; cyc = 0; run = 0; run_at_cpu = -1; cpu_done = 0;
    while (k < 10 && cyc < 20) begin
      cr = (cyc >= 1) && !cpu_done;
      step(1, cr, 0, 8'h41, 0, 1, 1, 1, 8'h20 + 8'(k), 8'(k));
      if (dma_gnt) begin k++; run++; end
      if (cr && !cpu_stall) begin cpu_done = 1; run_at_cpu = run; end
      cyc++;
    end
    expect_eq("t031_run", run_at_cpu, 8);
    expect_eq("t031_cycles", cyc, 11);
    expect_eq("t031_count", k, 10);
    idle(1);
    step(1, 1, 0, 8'h29, 0, 0, 0, 0, 0, 0);
    idle(1);
    expect_eq("t031_last", cpu_rdata, 8'h09);

    // DMA write then CPU read of the same byte.
    step(1, 0, 0, 0, 0, 1, 0, 1, 8'h40, 8'h33);
    step(1, 1, 0, 8'h40, 0, 0, 0, 0, 0, 0);
    expect_eq("t032_dv0", dma_rvalid, 0);
    idle(1);
    expect_eq("t032_rdata", cpu_rdata, 8'h33);
    expect_eq("t032_dv1", dma_rvalid, 0);

    // Reset the cycle after a CPU read grant discards the return.
    step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8'h10, 0, 1, 1, 0, 8'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    expect_eq("t033_rvalid", cpu_rvalid, 0);
    step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    expect_eq("t033_grant", mem_en, 1);

    // No requests.
    idle(3);
    expect_eq("t034_en", mem_en, 0);

    // Random traffic with requesters that hold their access until granted.
    c_pend = 0; d_pend = 0; d_burst = 0;
    c_we = 0; d_we = 0; c_a = 0; c_d = 0; d_a = 0; d_d = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!c_pend && $urandom_range(0, 3) < 3) begin
        c_pend = 1; c_we = 1'($urandom); c_a = 8'($urandom_range(0, 31)); c_d = 8'($urandom);
      end
      if (!d_pend && $urandom_range(0, 3) < 2) begin
        d_pend = 1; d_we = 1'($urandom); d_a = 8'($urandom_range(0, 31)); d_d = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) d_burst = ~d_burst;
      r = ($urandom_range(0, 299) != 0);
      step(r, c_pend, c_we, c_a, c_d, d_pend, d_burst, d_we, d_a, d_d);
      if (last_cw) c_pend = 0;
      if (last_dw) d_pend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 4, consecutive denied DMA cycles before DMA is forced to win.
REQ-002 SHALL have parameter BURST_MAX, default 8, maximum consecutive DMA grants while dma_burst is held.
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low.
REQ-005 SHALL have ports: cpu_req in 1, cpu_we in 1, cpu_addr in 8, cpu_wdata in 8  processor MEM-stage access.
REQ-006 SHALL have ports: cpu_stall out 1, cpu_rdata out 8, cpu_rvalid out 1  processor stall and read return.
REQ-007 SHALL have ports: dma_req in 1, dma_burst in 1, dma_we in 1, dma_addr in 8, dma_wdata in 8  loader/debug access.
REQ-008 SHALL have ports: dma_gnt out 1, dma_rdata out 8, dma_rvalid out 1  loader grant and read return.
REQ-009 SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out 8, mem_wdata out 8, mem_rdata in 8  256x8 data memory with synchronous read and 1-cycle latency.

Function
REQ-010 SHALL use a 3-state FSM: IDLE (no access last cycle), CPU (CPU owned last cycle), DMA (DMA owned last cycle).
REQ-011 SHALL pick one winner per cycle combinationally: default CPU wins whenever cpu_req=1.
REQ-012 SHALL let DMA win over CPU when starve_cnt==STARVE_LIM, or when state==DMA, dma_burst=1 and burst_cnt<BURST_MAX.
REQ-013 SHALL drive mem_en=1 and route the winner's we/addr/wdata to mem_* in the same cycle; no winner -> mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-014 SHALL drive cpu_stall = cpu_req AND NOT cpu-wins, combinationally.
REQ-015 SHALL drive dma_gnt = DMA-wins, combinationally; requester SHALL hold req/addr/wdata stable until granted or stalled-off.
REQ-016 SHALL assert cpu_rvalid (or dma_rvalid) for exactly one cycle, the cycle after a granted read (we=0) of that requester, with cpu_rdata/dma_rdata = mem_rdata.
REQ-017 SHALL hold cpu_rdata/dma_rdata at their last returned value when the matching rvalid is 0.
REQ-018 SHALL not assert any rvalid after a granted write.
REQ-019 SHALL keep starve_cnt (3-bit): +1 each cycle dma_req=1 and DMA loses, saturating at STARVE_LIM; cleared on any DMA grant or when dma_req=0.
REQ-020 SHALL keep burst_cnt (4-bit): set to 1 on a DMA grant from IDLE/CPU, +1 on each further consecutive DMA grant, cleared when state leaves DMA.
REQ-021 SHALL end a burst when burst_cnt reaches BURST_MAX; CPU then wins the next cycle if cpu_req=1, before DMA can win again.
REQ-022 SHALL transition next state to CPU, DMA or IDLE per that cycle's winner (none -> IDLE).
REQ-023 SHALL treat simultaneous cpu_req and dma_req with starve_cnt<STARVE_LIM and no active burst as a CPU win.
REQ-024 SHALL apply a dma_burst deassert in the same cycle: normal CPU priority resumes immediately.

Reset
REQ-025 SHALL on reset=0 immediately force state=IDLE, starve_cnt=0, burst_cnt=0, cpu_rvalid=0, dma_rvalid=0, cpu_rdata=0, dma_rdata=0.
REQ-026 SHALL hold mem_en=0, mem_we=0, dma_gnt=0 and cpu_stall=0 while reset=0, regardless of requests.
REQ-027 SHALL discard a read in flight when reset asserts mid-access: no rvalid after release.
REQ-028 SHALL grant normally on the first rising edge after reset=1.

Verification
REQ-029 SHALL cover: CPU read addr 0x10 (mem=0x5A) alone -> mem_en=1 same cycle, cpu_rvalid=1 with cpu_rdata=0x5A next cycle, cpu_stall=0.
REQ-030 SHALL cover: cpu_req and dma_req held together -> CPU wins 4 cycles, DMA granted on cycle 5, cpu_stall=1 that cycle only.
REQ-031 SHALL cover: dma_burst=1 writes 0..9 to addr 0x20.. with cpu_req=1 -> 8 consecutive DMA grants, then one CPU grant, then DMA resumes.
REQ-032 SHALL cover: DMA write 0x33 to 0x40, then CPU read 0x40 -> cpu_rdata=0x33, no dma_rvalid.
REQ-033 SHALL cover: reset=0 asserted the cycle after a CPU read grant -> no cpu_rvalid, all outputs at reset values, normal grant after release.
REQ-034 SHALL cover: no requests for 3 cycles -> mem_en=0, state IDLE, starve_cnt=0.
